// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep reader.
// Holds the sweep FSM state encoding and the binary-to-Gray helper.
package tt_pkg;

    localparam int N_IN_DEF = 3;
    localparam int TT_W_DEF = 2 ** N_IN_DEF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tt_state_e;

    function automatic logic [7:0] bin2gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags when the settle wait has elapsed.
// Holds at zero once expired until it is reloaded.
module tt_settle_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    // Load takes priority; otherwise count down while enabled.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps every input row of a truth-table function and captures its code.
// Optional TT_SWEEP_GRAY_EN drives rows in Gray order.
module tt_sweep_capture
    import tt_pkg::*;
#(
    parameter int N_IN          = N_IN_DEF,
    parameter int SETTLE_CYCLES = 4,
    localparam int TT_W         = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    output logic [N_IN-1:0] stim,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] result,
    output logic            match
);

    localparam logic [7:0] LOAD_VAL =
        (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;

    // With no settle wait, each new stimulus is sampled on the next edge.
    localparam tt_state_e AFTER_STIM =
        (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    tt_state_e       state_q;
    logic [N_IN-1:0] row_q;
    logic [N_IN-1:0] stim_q;
    logic [TT_W-1:0] exp_q;
    logic [TT_W-1:0] result_q;
    logic            busy_q;
    logic            done_q;
    logic            match_q;

    logic [N_IN-1:0] row_nxt;
    logic [N_IN-1:0] stim_nxt;
    logic [N_IN-1:0] bit_idx;
    logic            last_row;
    logic            tmr_load;
    logic            tmr_en;
    logic            tmr_expired;

    assign row_nxt  = row_q + 1'b1;
    assign last_row = (row_q == N_IN'(TT_W - 1));

`ifdef TT_SWEEP_GRAY_EN
    assign stim_nxt = N_IN'(bin2gray(8'(row_nxt)));
`else
    assign stim_nxt = row_nxt;
`endif

    // Pattern p lands in bit TT_W-1-p, which is the bitwise inverse of p.
    assign bit_idx = ~stim_q;

    assign tmr_load = ((state_q == IDLE) && start) ||
                      ((state_q == SAMPLE) && !last_row);
    assign tmr_en   = (state_q == SETTLE);

    tt_settle_timer #(
        .W(8)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .load_i    (tmr_load),
        .load_val_i(LOAD_VAL),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Sweep sequencer with registered outputs and in-place result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            stim_q   <= '0;
            exp_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        exp_q    <= expected;
                        row_q    <= '0;
                        stim_q   <= '0;
                        result_q <= '0;
                        match_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= AFTER_STIM;
                    end
                end
                SETTLE: begin
                    if (tmr_expired) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    result_q[bit_idx] <= resp;
                    if (!last_row) begin
                        row_q   <= row_nxt;
                        stim_q  <= stim_nxt;
                        state_q <= AFTER_STIM;
                    end else begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    stim_q  <= '0;
                    match_q <= (result_q == exp_q);
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stim   = stim_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign match  = match_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Scoreboard bench for tt_sweep_capture with settle waits of 4 and 0.
// Stimulus order is checked as Gray when TT_SWEEP_GRAY_EN is defined.
module tb_tt_sweep_capture;
    import tt_pkg::*;

    localparam int LAT_A = 8 * (4 + 1) + 1;
    localparam int LAT_B = 8 * (0 + 1) + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [7:0] exp_a, exp_b;
    logic [2:0] stim_a, stim_b;
    logic       resp_a, resp_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;
    logic [7:0] result_a, result_b;
    logic       match_a, match_b;

    logic [7:0] code_a, code_b;
    logic       xor_b;

    // Functions under test: a table lookup, or a 3-input XOR.
    assign resp_a = code_a[3'd7 - stim_a];
    assign resp_b = xor_b ? ^stim_b : code_b[3'd7 - stim_b];

    tt_sweep_capture #(.N_IN(3), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .expected(exp_a), .stim(stim_a), .resp(resp_a),
        .busy(busy_a), .done(done_a), .result(result_a),
        .match(match_a)
    );

    tt_sweep_capture #(.N_IN(3), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .expected(exp_b), .stim(stim_b), .resp(resp_b),
        .busy(busy_b), .done(done_b), .result(result_b),
        .match(match_b)
    );

    typedef struct {
        logic [7:0] res;
        logic       m;
        int         when;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Reference: bit (7-p) of the code is the function value at pattern p.
    function automatic logic [7:0] model_tt(input logic [7:0] code,
                                            input logic is_xor);
        logic [7:0] v;
        logic [2:0] p;
        v = '0;
        for (int r = 0; r < 8; r++) begin
            p = 3'(r);
            v[7-r] = is_xor ? ^p : code[7-r];
        end
        return v;
    endfunction

    // Monitor A: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (done_a) begin
            if (qa.size() == 0) begin
                check("spurious_done_a", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("result_a", result_a, ea.res);
                check("match_a", match_a, ea.m);
                check("latency_a", cyc, ea.when);
            end
        end
    end

    always @(negedge clk) begin
        if (done_b) begin
            if (qb.size() == 0) begin
                check("spurious_done_b", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("result_b", result_b, eb.res);
                check("match_b", match_b, eb.m);
                check("latency_b", cyc, eb.when);
            end
        end
    end

    // Stimulus ordering: one step per sample while busy.
    logic [2:0] prev_a = '0;
    logic [2:0] prev_b = '0;

    always @(negedge clk) begin
        if (!busy_a) begin
            prev_a <= '0;
        end else if (stim_a != prev_a) begin
`ifdef TT_SWEEP_GRAY_EN
            check("stim_step_a", $countones(stim_a ^ prev_a), 1);
`else
            check("stim_step_a", stim_a, 3'(prev_a + 3'd1));
`endif
            prev_a <= stim_a;
        end
    end

    always @(negedge clk) begin
        if (!busy_b) begin
            prev_b <= '0;
        end else if (stim_b != prev_b) begin
`ifdef TT_SWEEP_GRAY_EN
            check("stim_step_b", $countones(stim_b ^ prev_b), 1);
`else
            check("stim_step_b", stim_b, 3'(prev_b + 3'd1));
`endif
            prev_b <= stim_b;
        end
    end

    task automatic wait_empty_a();
        int k = 0;
        while (qa.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (qa.size() != 0) begin
            check("timeout_a", qa.size(), 0);
            qa.delete();
        end
    endtask

    task automatic wait_empty_b();
        int k = 0;
        while (qb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (qb.size() != 0) begin
            check("timeout_b", qb.size(), 0);
            qb.delete();
        end
    endtask

    task automatic sweep_a(input logic [7:0] code,
                           input logic [7:0] expv,
                           input bit poke);
        exp_t e;
        wait_empty_a();
        @(negedge clk);
        code_a  = code;
        exp_a   = expv;
        start_a = 1'b1;
        e.res   = model_tt(code, 1'b0);
        e.m     = (e.res == expv);
        e.when  = cyc + 1 + LAT_A;
        qa.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        if (poke) begin
            repeat (5) @(negedge clk);
            start_a = 1'b1;
            exp_a   = ~expv;
            @(negedge clk);
            start_a = 1'b0;
        end
    endtask

    task automatic sweep_b(input logic [7:0] code,
                           input logic [7:0] expv,
                           input logic is_xor,
                           input bit poke);
        exp_t e;
        wait_empty_b();
        @(negedge clk);
        code_b  = code;
        xor_b   = is_xor;
        exp_b   = expv;
        start_b = 1'b1;
        e.res   = model_tt(code, is_xor);
        e.m     = (e.res == expv);
        e.when  = cyc + 1 + LAT_B;
        qb.push_back(e);
        @(negedge clk);
        start_b = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            start_b = 1'b1;
            exp_b   = ~expv;
            @(negedge clk);
            start_b = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c;
        logic [7:0] x;
        int base;
        exp_t e;

        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        exp_a   = '0;
        exp_b   = '0;
        code_a  = 8'h87;
        code_b  = 8'h00;
        xor_b   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_stim_a", stim_a, 0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_result_a", result_a, 0);
        check("rst_match_a", match_a, 0);
        check("rst_stim_b", stim_b, 0);
        check("rst_busy_b", busy_b, 0);
        check("rst_result_b", result_b, 0);
        rst_n = 1'b1;

        sweep_a(8'h87, 8'h87, 1'b0);
        sweep_a(8'h87, 8'h88, 1'b1);
        sweep_b(8'h00, 8'h69, 1'b1, 1'b0);
        sweep_b(8'h00, 8'h00, 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            c = 8'($urandom);
            x = $urandom_range(0, 1) ? c : 8'($urandom);
            sweep_a(c, x, (i % 2) == 1);
            c = 8'($urandom);
            x = $urandom_range(0, 1) ? c : 8'($urandom);
            sweep_b(c, x, 1'b0, (i % 2) == 0);
        end
        wait_empty_a();
        wait_empty_b();

        // Abort a sweep with reset around its 20th cycle.
        @(negedge clk);
        code_a  = 8'h87;
        exp_a   = 8'h87;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_stim", stim_a, 0);
        check("abort_busy", busy_a, 0);
        check("abort_done", done_a, 0);
        check("abort_result", result_a, 0);
        check("abort_match", match_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("abort_idle_busy", busy_a, 0);

        sweep_a(8'h87, 8'h87, 1'b0);
        wait_empty_a();

        // Start held high: back-to-back sweeps every LAT_A+1 cycles.
        @(negedge clk);
        code_a  = 8'h5a;
        exp_a   = 8'h5a;
        start_a = 1'b1;
        base    = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            e.res  = model_tt(8'h5a, 1'b0);
            e.m    = 1'b1;
            e.when = base + k * (LAT_A + 1) + LAT_A;
            qa.push_back(e);
        end
        repeat (2 * (LAT_A + 1) + 1) @(negedge clk);
        start_a = 1'b0;
        wait_empty_a();
        repeat (50) @(negedge clk);
        check("b2b_idle_busy", busy_a, 0);

        wait_empty_a();
        wait_empty_b();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
